bram_port_arbiter: RTL and testbench



---
 rtl/bram_arb_pkg.sv | 19 +
 rtl/bram_port_arbiter_if.sv | 32 +++
 rtl/bram_arb_pick.sv | 36 +++
 rtl/bram_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_arb_pkg.sv
// Package: bram_arb_pkg
// Shared types and constants for the BRAM port-b arbiter.
//   state_e : arbiter FSM states (IDLE = normal arbitration, CLEAR = whole-memory clear)
//   mid_t   : master identifier (one bit, two requesters)
//   M_CORE  : id of the core load/store unit (m0)
//   M_HOST  : id of the host loader / debug port (m1)
package bram_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef logic mid_t;

  localparam mid_t M_CORE = 1'b0;
  localparam mid_t M_HOST = 1'b1;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Interface: bram_req_if
// One requester's req/gnt/rvalid handshake toward the shared BRAM port.
//   req/addr/we/be/wdata : request side, driven by the requester (master)
//   gnt                  : combinational grant, same cycle as req
//   rvalid/rdata         : response one cycle after gnt; rdata is 0 when rvalid is 0
// Modports: master = requester view, slave = arbiter view.
interface bram_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) ();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/bram_arb_pick.sv
// Module: bram_arb_pick
// Purely combinational grant picker: two request bits -> one-hot grant.
// Build option BRAM_ARB_RR_EN:
//   defined   : round-robin; on a simultaneous request the master that is not ptr wins,
//               a lone requester always wins. Adds the ptr input.
//   undefined : fixed priority, m0 (core) over m1 (host).
// Ports:
//   req [1:0] : request bits, bit N = master N
//   ptr       : id of the most recently granted master (round-robin build only)
//   gnt [1:0] : one-hot grant, zero when nothing requests
module bram_arb_pick
  import bram_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef BRAM_ARB_RR_EN
  input  mid_t       ptr,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
`ifdef BRAM_ARB_RR_EN
    if (req == 2'b11) begin
      // Contention: hand the port to whoever did not have it last.
      gnt = (ptr == M_CORE) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
`else
    gnt[0] = req[0];
    gnt[1] = req[1] & ~req[0];
`endif
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Module: bram_port_arbiter
// Shares one BRAM port-b between the core LSU (m0) and the host loader/debug port (m1),
// and sequences a whole-memory clear through mem_rstb, blocking grants until it finishes.
// Build option BRAM_ARB_RR_EN selects round-robin arbitration (default: m0 over m1).
// Ports:
//   clk, reset_n        : clock (forwarded on mem_clkb), asynchronous active-low reset
//   clear_i             : pulse to request a whole-memory clear (ignored during a clear)
//   clear_done_o        : one-cycle pulse on the last CLEAR cycle
//   busy_o              : high while the FSM is in CLEAR
//   m0, m1              : requester handshakes (bram_req_if.slave)
//   mem_clkb/enb/rstb   : BRAM clock, enable, clear strobe
//   mem_web             : byte write enables (be when we, else 0)
//   mem_addrb/dinb      : granted address / write data, 0 when idle
//   mem_doutb           : BRAM registered read data (1-cycle latency)
//   mem_rstb_busy       : BRAM reports its clear still in progress
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  output logic              clear_done_o,
  output logic              busy_o,
  bram_req_if.slave         m0,
  bram_req_if.slave         m1,
  output logic              mem_clkb,
  output logic              mem_enb,
  output logic              mem_rstb,
  output logic [BE_W-1:0]   mem_web,
  output logic [ADDR_W-1:0] mem_addrb,
  output logic [DATA_W-1:0] mem_dinb,
  input  logic [DATA_W-1:0] mem_doutb,
  input  logic              mem_rstb_busy
);

  state_e     state_q, state_d;
  logic       first_q, first_d;   // marks the first CLEAR cycle (the mem_rstb strobe)
  logic       arb_en;
  logic [1:0] req_vec;
  logic [1:0] pick_gnt;
  logic [1:0] gnt;
  mid_t       gnt_id;
  logic       valid_q;
  mid_t       owner_q;
  logic [1:0] rvalid_vec;

  assign mem_clkb = clk;
  assign req_vec  = {m1.req, m0.req};

`ifdef BRAM_ARB_RR_EN
  mid_t rr_ptr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= M_CORE;
    end else if (|gnt) begin
      rr_ptr_q <= gnt_id;
    end
  end

  bram_arb_pick u_pick (
    .req (req_vec),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt)
  );
`else
  bram_arb_pick u_pick (
    .req (req_vec),
    .gnt (pick_gnt)
  );
`endif

  // Gating with reset_n forces the combinational grant (and everything fed by it)
  // low the moment reset asserts, not at the next edge.
  assign gnt    = pick_gnt & {2{arb_en & reset_n}};
  assign gnt_id = gnt[1] ? M_HOST : M_CORE;
  assign m0.gnt = gnt[0];
  assign m1.gnt = gnt[1];

  // FSM next state / outputs
  always_comb begin
    state_d      = state_q;
    first_d      = 1'b0;
    arb_en       = 1'b0;
    mem_rstb     = 1'b0;
    busy_o       = 1'b0;
    clear_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          // The clear request cycle grants nothing.
          state_d = CLEAR;
          first_d = 1'b1;
        end else begin
          arb_en = 1'b1;
        end
      end
      CLEAR: begin
        busy_o = 1'b1;
        if (first_q) begin
          mem_rstb = 1'b1;
        end else if (!mem_rstb_busy) begin
          // mem_rstb_busy is only trusted after the strobe cycle, so the BRAM
          // has had a chance to raise it.
          clear_done_o = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      valid_q <= 1'b0;
      owner_q <= M_CORE;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      valid_q <= |gnt;
      if (|gnt) begin
        owner_q <= gnt_id;
      end
    end
  end

  // Port-b mux: the granted master drives the BRAM, otherwise everything is 0.
  always_comb begin
    mem_enb   = |gnt;
    mem_web   = '0;
    mem_addrb = '0;
    mem_dinb  = '0;
    if (gnt[0]) begin
      mem_web   = m0.we ? m0.be : '0;
      mem_addrb = m0.addr;
      mem_dinb  = m0.wdata;
    end else if (gnt[1]) begin
      mem_web   = m1.we ? m1.be : '0;
      mem_addrb = m1.addr;
      mem_dinb  = m1.wdata;
    end
  end

  // Response routing: the BRAM output belongs to whoever was granted last cycle.
  // Writes get a response too; the BRAM returns the merged word.
  assign rvalid_vec[0] = valid_q & (owner_q == M_CORE);
  assign rvalid_vec[1] = valid_q & (owner_q == M_HOST);

  assign m0.rvalid = rvalid_vec[0];
  assign m1.rvalid = rvalid_vec[1];
  assign m0.rdata  = rvalid_vec[0] ? mem_doutb : '0;
  assign m1.rdata  = rvalid_vec[1] ? mem_doutb : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench: tb_bram_port_arbiter
// Directed stimulus for bram_port_arbiter against a small behavioural BRAM
// (write-first, 1-cycle registered read, clear on mem_rstb). Expected responses
// are queued when a request is issued; a negedge monitor pops and compares them
// whenever a response valid appears. Handshake / clear signals are checked
// directly by the stimulus process one delta after it drives each cycle.
module tb_bram_port_arbiter;

  logic        tb_clk;
  logic        rstb;
  logic        clear_i;
  logic        clear_done;
  logic        busy;
  logic        mem_clkb;
  logic        mem_enb;
  logic        mem_rstb;
  logic [3:0]  mem_web;
  logic [31:0] mem_addrb;
  logic [31:0] mem_dinb;
  logic [31:0] mem_doutb;
  logic        mem_rstb_busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;

  logic [31:0] bram [64];
  logic [31:0] bram_word;

  bram_req_if #(.ADDR_W(32), .DATA_W(32), .BE_W(4)) m0_bus ();
  bram_req_if #(.ADDR_W(32), .DATA_W(32), .BE_W(4)) m1_bus ();

  bram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BE_W(4)) dut (
    .clk           (tb_clk),
    .reset_n       (rstb),
    .clear_i       (clear_i),
    .clear_done_o  (clear_done),
    .busy_o        (busy),
    .m0            (m0_bus),
    .m1            (m1_bus),
    .mem_clkb      (mem_clkb),
    .mem_enb       (mem_enb),
    .mem_rstb      (mem_rstb),
    .mem_web       (mem_web),
    .mem_addrb     (mem_addrb),
    .mem_dinb      (mem_dinb),
    .mem_doutb     (mem_doutb),
    .mem_rstb_busy (mem_rstb_busy)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Behavioural BRAM. The image is (re)loaded while the bench holds reset.
  always @(posedge tb_clk) begin
    if (!rstb) begin
      for (int i = 0; i < 64; i++) bram[i] <= '0;
      bram[4]   <= 32'hDEADBEEF;
      bram[8]   <= 32'h11223344;
      mem_doutb <= '0;
    end else if (mem_rstb) begin
      for (int i = 0; i < 64; i++) bram[i] <= '0;
      mem_doutb <= '0;
    end else if (mem_enb) begin
      bram_word = bram[mem_addrb[7:2]];
      for (int b = 0; b < 4; b++) begin
        if (mem_web[b]) bram_word[8*b +: 8] = mem_dinb[8*b +: 8];
      end
      bram[mem_addrb[7:2]] <= bram_word;
      mem_doutb            <= bram_word;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] data);
    rsp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic drop_reqs();
    m0_bus.req = 1'b0; m0_bus.addr = '0; m0_bus.we = 1'b0; m0_bus.be = '0; m0_bus.wdata = '0;
    m1_bus.req = 1'b0; m1_bus.addr = '0; m1_bus.we = 1'b0; m1_bus.be = '0; m1_bus.wdata = '0;
  endtask

  task automatic set_req(input logic id, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata);
    if (id == 1'b0) begin
      m0_bus.req = 1'b1; m0_bus.addr = addr; m0_bus.we = we; m0_bus.be = be; m0_bus.wdata = wdata;
    end else begin
      m1_bus.req = 1'b1; m1_bus.addr = addr; m1_bus.we = we; m1_bus.be = be; m1_bus.wdata = wdata;
    end
  endtask

  // Response monitor / scoreboard
  always @(negedge tb_clk) begin
    if (m0_bus.rvalid || m1_bus.rvalid) begin
      chk("rvalid_onehot", {31'd0, m0_bus.rvalid & m1_bus.rvalid}, 32'd0);
      chk("rsp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        $display("rsp m%0d data=0x%08h (exp m%0d 0x%08h)", m1_bus.rvalid ? 1 : 0,
                 m1_bus.rvalid ? m1_bus.rdata : m0_bus.rdata, mon_e.id, mon_e.data);
        chk("rsp_owner", {31'd0, m1_bus.rvalid}, {31'd0, mon_e.id});
        chk("rsp_data", m1_bus.rvalid ? m1_bus.rdata : m0_bus.rdata, mon_e.data);
        chk("rsp_other_rdata", m1_bus.rvalid ? m0_bus.rdata : m1_bus.rdata, 32'd0);
      end
    end else begin
      chk("rdata_idle_zero", m0_bus.rdata | m1_bus.rdata, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_id;
    rstb          = 1'b0;
    clear_i       = 1'b0;
    mem_rstb_busy = 1'b0;
    drop_reqs();

    // Reset state
    repeat (2) @(posedge tb_clk);
    #1;
    chk("rst_gnt", {30'd0, m1_bus.gnt, m0_bus.gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, m1_bus.rvalid, m0_bus.rvalid}, 32'd0);
    chk("rst_mem", {26'd0, mem_enb, mem_rstb, mem_web}, 32'd0);
    chk("rst_status", {30'd0, clear_done, busy}, 32'd0);
    rstb = 1'b1;

    // 1: m0 read @0x10
    cyc();
    set_req(1'b0, 32'h10, 1'b0, 4'h0, 32'h0);
    #1;
    $display("req m0 rd @0x10");
    chk("t1_gnt0", {31'd0, m0_bus.gnt}, 32'd1);
    chk("t1_gnt1", {31'd0, m1_bus.gnt}, 32'd0);
    chk("t1_enb", {31'd0, mem_enb}, 32'd1);
    chk("t1_addrb", mem_addrb, 32'h10);
    chk("t1_web", {28'd0, mem_web}, 32'd0);
    push(1'b0, 32'hDEADBEEF);
    cyc();
    drop_reqs();

    // 2: both masters request every cycle
    for (int k = 0; k < 4; k++) begin
      cyc();
      set_req(1'b0, 32'h10, 1'b0, 4'h0, 32'h0);
      set_req(1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
      #1;
`ifdef BRAM_ARB_RR_EN
      exp_id = (k % 2 == 0) ? 1'b1 : 1'b0;
`else
      exp_id = 1'b0;
`endif
      $display("req m0+m1 rd cycle %0d", k);
      chk("t2_gnt", {30'd0, m1_bus.gnt, m0_bus.gnt}, exp_id ? 32'd2 : 32'd1);
      push(exp_id, exp_id ? 32'h11223344 : 32'hDEADBEEF);
    end
    cyc();
    drop_reqs();

    // 3: m1 byte write then m0 read of the merged word
    cyc();
    set_req(1'b1, 32'h20, 1'b1, 4'b0001, 32'h000000A5);
    #1;
    $display("req m1 wr @0x20 be=0001");
    chk("t3_gnt1", {31'd0, m1_bus.gnt}, 32'd1);
    chk("t3_web", {28'd0, mem_web}, 32'd1);
    chk("t3_dinb", mem_dinb, 32'hA5);
    push(1'b1, 32'h112233A5);
    cyc();
    drop_reqs();
    set_req(1'b0, 32'h20, 1'b0, 4'h0, 32'h0);
    #1;
    $display("req m0 rd @0x20");
    chk("t3_gnt0", {31'd0, m0_bus.gnt}, 32'd1);
    push(1'b0, 32'h112233A5);
    cyc();
    drop_reqs();

    // 4: clear while m0 requests; the response owed from the prior grant still lands
    cyc();
    set_req(1'b0, 32'h10, 1'b0, 4'h0, 32'h0);
    #1;
    $display("req m0 rd @0x10 before clear");
    chk("t4_gnt0_pre", {31'd0, m0_bus.gnt}, 32'd1);
    push(1'b0, 32'hDEADBEEF);
    cyc();
    clear_i = 1'b1;
    #1;
    $display("clear_i with m0 pending");
    chk("t4_gnt0_clrreq", {31'd0, m0_bus.gnt}, 32'd0);
    chk("t4_enb_clrreq", {31'd0, mem_enb}, 32'd0);
    cyc();
    clear_i = 1'b0;
    #1;
    chk("t4_rstb", {31'd0, mem_rstb}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    chk("t4_gnt0_clr", {31'd0, m0_bus.gnt}, 32'd0);
    chk("t4_done_early", {31'd0, clear_done}, 32'd0);
    cyc();
    chk("t4_rstb_once", {31'd0, mem_rstb}, 32'd0);
    chk("t4_done", {31'd0, clear_done}, 32'd1);
    chk("t4_gnt0_done", {31'd0, m0_bus.gnt}, 32'd0);
    cyc();
    chk("t4_busy_idle", {31'd0, busy}, 32'd0);
    chk("t4_gnt0_after", {31'd0, m0_bus.gnt}, 32'd1);
    push(1'b0, 32'h0);
    cyc();
    drop_reqs();

    // 5: BRAM holds busy for 3 cycles; a clear_i pulse inside CLEAR is ignored
    cyc();
    set_req(1'b1, 32'h20, 1'b1, 4'b1111, 32'hCAFEF00D);
    #1;
    $display("req m1 wr @0x20 be=1111");
    chk("t5_gnt1_wr", {31'd0, m1_bus.gnt}, 32'd1);
    push(1'b1, 32'hCAFEF00D);
    cyc();
    drop_reqs();
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    #1;
    $display("clear with busy hold");
    chk("t5_rstb", {31'd0, mem_rstb}, 32'd1);
    for (int j = 0; j < 3; j++) begin
      cyc();
      mem_rstb_busy = 1'b1;
      clear_i       = (j == 1);
      #1;
      chk("t5_hold", {29'd0, mem_rstb, busy, clear_done}, 32'd2);
    end
    cyc();
    mem_rstb_busy = 1'b0;
    clear_i       = 1'b0;
    #1;
    chk("t5_done", {30'd0, busy, clear_done}, 32'd3);
    cyc();
    set_req(1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
    #1;
    $display("req m1 rd @0x20 after clear");
    chk("t5_idle", {30'd0, busy, clear_done}, 32'd0);
    chk("t5_gnt1", {31'd0, m1_bus.gnt}, 32'd1);
    push(1'b1, 32'h0);
    cyc();
    drop_reqs();

    // 6: reset asserted after a grant, before the response edge
    cyc();
    set_req(1'b0, 32'h10, 1'b0, 4'h0, 32'h0);
    #1;
    $display("req m0 rd @0x10 then reset");
    chk("t6_gnt0", {31'd0, m0_bus.gnt}, 32'd1);
    #1;
    rstb = 1'b0;
    #1;
    chk("t6_async_gnt", {30'd0, m1_bus.gnt, m0_bus.gnt}, 32'd0);
    chk("t6_async_mem", {26'd0, mem_enb, mem_rstb, mem_web}, 32'd0);
    chk("t6_async_addr", mem_addrb, 32'd0);
    for (int j = 0; j < 2; j++) begin
      cyc();
      chk("t6_rst_hold", {28'd0, m0_bus.gnt, m0_bus.rvalid, busy, clear_done}, 32'd0);
    end
    drop_reqs();
    cyc();
    rstb = 1'b1;
    cyc();
    cyc();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
